// File: rtl/conv_stream_framer.sv
// Splits one AXI-stream frame into a kernel block (written to BRAM) followed by
// image beats tagged with channel/frame boundaries, with error flagging on bad framing.
module conv_stream_framer #(
    parameter int DATA_WIDTH  = 256,
    parameter int MAX_CH      = 256,
    parameter int MAX_IMG_SEL = 4,
    localparam int CH_W       = (MAX_CH > 1) ? $clog2(MAX_CH) : 1,
    localparam int PIX_W      = 2 * (MAX_IMG_SEL + 2)
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [2:0]            image_size_sel,
    input  logic [1:0]            channel_size_sel,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  kernel_wr_en,
    output logic [CH_W-1:0]       kernel_wr_addr,
    output logic [DATA_WIDTH-1:0] kernel_wr_data,
    output logic [DATA_WIDTH-1:0] pix_tdata,
    output logic                  pix_tvalid,
    input  logic                  pix_tready,
    output logic                  pix_last_ch,
    output logic                  pix_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  err_early_tlast,
    output logic                  err_missing_tlast,
    output logic                  err_cfg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] KERNEL = 2'd1;
    localparam logic [1:0] IMAGE  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [2:0] MAX_SEL = 3'(MAX_IMG_SEL);

    logic [1:0]       state;
    logic [2:0]       img_sel_q;
    logic [1:0]       ch_sel_q;
    logic [CH_W-1:0]  ch_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic             last_in;    // final frame beat already accepted, wait for it to drain

    logic [CH_W-1:0]  ch_max;
    logic [PIX_W-1:0] pix_max;
    logic [4:0]       pix_shamt;
    logic             ch_wrap;
    logic             final_beat;
    logic             acc;
    logic             pix_xfer;

    // side*side - 1 is an all-ones mask of 2*sel+4 bits
    assign pix_shamt  = 5'(2 * MAX_IMG_SEL) - {1'b0, img_sel_q, 1'b0};
    assign pix_max    = {PIX_W{1'b1}} >> pix_shamt;
    assign ch_max     = CH_W'(MAX_CH - 1) >> ch_sel_q;
    assign ch_wrap    = (ch_cnt == ch_max);
    assign final_beat = ch_wrap && (pix_cnt == pix_max);

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign s_axis_tready = (state == KERNEL) ||
                           ((state == IMAGE) && !last_in && (!pix_tvalid || pix_tready));
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign pix_xfer      = pix_tvalid && pix_tready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= IDLE;
            img_sel_q         <= '0;
            ch_sel_q          <= '0;
            ch_cnt            <= '0;
            pix_cnt           <= '0;
            last_in           <= 1'b0;
            kernel_wr_en      <= 1'b0;
            kernel_wr_addr    <= '0;
            kernel_wr_data    <= '0;
            pix_tdata         <= '0;
            pix_tvalid        <= 1'b0;
            pix_last_ch       <= 1'b0;
            pix_tlast         <= 1'b0;
            err_early_tlast   <= 1'b0;
            err_missing_tlast <= 1'b0;
            err_cfg           <= 1'b0;
        end else begin
            kernel_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err_early_tlast   <= 1'b0;
                        err_missing_tlast <= 1'b0;
                        if (image_size_sel > MAX_SEL) begin
                            err_cfg <= 1'b1;
                        end else begin
                            err_cfg   <= 1'b0;
                            img_sel_q <= image_size_sel;
                            ch_sel_q  <= channel_size_sel;
                            ch_cnt    <= '0;
                            pix_cnt   <= '0;
                            last_in   <= 1'b0;
                            state     <= KERNEL;
                        end
                    end
                end
                KERNEL: begin
                    if (acc) begin
                        // any tlast here precedes the image phase, so it is always early
                        if (s_axis_tlast) begin
                            err_early_tlast <= 1'b1;
                            ch_cnt          <= '0;
                            state           <= IDLE;
                        end else begin
                            kernel_wr_en   <= 1'b1;
                            kernel_wr_addr <= ch_cnt;
                            kernel_wr_data <= s_axis_tdata;
                            if (ch_wrap) begin
                                ch_cnt <= '0;
                                state  <= IMAGE;
                            end else begin
                                ch_cnt <= ch_cnt + 1'b1;
                            end
                        end
                    end
                end
                IMAGE: begin
                    if (acc && s_axis_tlast && !final_beat) begin
                        err_early_tlast <= 1'b1;
                        pix_tvalid      <= 1'b0;
                        state           <= IDLE;
                    end else if (pix_xfer && pix_tlast) begin
                        pix_tvalid <= 1'b0;
                        state      <= DONE;
                    end else if (acc) begin
                        pix_tvalid  <= 1'b1;
                        pix_tdata   <= s_axis_tdata;
                        pix_last_ch <= ch_wrap;
                        pix_tlast   <= final_beat;
                        if (ch_wrap) begin
                            ch_cnt  <= '0;
                            pix_cnt <= pix_cnt + 1'b1;
                        end else begin
                            ch_cnt <= ch_cnt + 1'b1;
                        end
                        if (final_beat) begin
                            last_in <= 1'b1;
                            if (!s_axis_tlast) err_missing_tlast <= 1'b1;
                        end
                    end else if (pix_xfer) begin
                        pix_tvalid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_framer.sv
// Scoreboard bench: driver queues expected kernel writes / pix beats, monitor pops on each output.
module tb_conv_stream_framer;

    localparam int DW = 256;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          start;
    logic [2:0]    image_size_sel;
    logic [1:0]    channel_size_sel;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          kernel_wr_en;
    logic [CW-1:0] kernel_wr_addr;
    logic [DW-1:0] kernel_wr_data;
    logic [DW-1:0] pix_tdata;
    logic          pix_tvalid;
    logic          pix_tready;
    logic          pix_last_ch;
    logic          pix_tlast;
    logic          busy;
    logic          done;
    logic          err_early_tlast;
    logic          err_missing_tlast;
    logic          err_cfg;

    always #5 clk = ~clk;

    conv_stream_framer #(.DATA_WIDTH(DW), .MAX_CH(256), .MAX_IMG_SEL(4)) dut (
        .clk(clk), .aresetn(aresetn), .start(start),
        .image_size_sel(image_size_sel), .channel_size_sel(channel_size_sel),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .kernel_wr_en(kernel_wr_en), .kernel_wr_addr(kernel_wr_addr),
        .kernel_wr_data(kernel_wr_data), .pix_tdata(pix_tdata),
        .pix_tvalid(pix_tvalid), .pix_tready(pix_tready),
        .pix_last_ch(pix_last_ch), .pix_tlast(pix_tlast), .busy(busy), .done(done),
        .err_early_tlast(err_early_tlast), .err_missing_tlast(err_missing_tlast),
        .err_cfg(err_cfg)
    );

    typedef struct packed { logic [CW-1:0] addr; logic [DW-1:0] data; } kexp_t;
    typedef struct packed { logic [DW-1:0] data; logic last_ch; logic tlast; } pexp_t;

    kexp_t kq[$];
    pexp_t pq[$];
    int    tests = 0;
    int    fails = 0;
    int    done_cnt = 0;
    int    kwr_seen = 0;
    int    pix_seen = 0;
    bit    toggle_mode = 1'b0;
    int    tog = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input int fid, input int k);
        return {192'(fid), 32'(k), ~32'(k)};
    endfunction

    // downstream ready: always 1, or high one cycle in three
    always @(posedge clk) begin
        #1;
        tog++;
        pix_tready = toggle_mode ? ((tog % 3) == 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (aresetn) begin
            kexp_t ke;
            pexp_t pe;
            if (done) done_cnt++;
            if (kernel_wr_en) begin
                kwr_seen++;
                if (kq.size() == 0) chk("kernel_unexpected", 256'(kernel_wr_addr), '1);
                else begin
                    ke = kq.pop_front();
                    chk("kernel_addr", 256'(kernel_wr_addr), 256'(ke.addr));
                    chk("kernel_data", kernel_wr_data, ke.data);
                end
            end
            if (pix_tvalid && pix_tready) begin
                pix_seen++;
                if (pq.size() == 0) chk("pix_unexpected", pix_tdata, '1);
                else begin
                    pe = pq.pop_front();
                    chk("pix_data", pix_tdata, pe.data);
                    chk("pix_flags", 256'({pix_last_ch, pix_tlast}), 256'({pe.last_ch, pe.tlast}));
                end
            end
            if (toggle_mode && pix_tvalid && !pix_tready)
                chk("hold_tready", 256'(s_axis_tready), 256'(0));
        end
    end

    task automatic do_start(input logic [2:0] isel, input logic [1:0] csel);
        @(posedge clk); #1;
        start = 1'b1; image_size_sel = isel; channel_size_sel = csel;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_acc(output bit ok);
        int n = 0;
        bit a;
        do begin
            @(negedge clk);
            a = s_axis_tready;
            @(posedge clk); #1;
            n++;
        end while (!a && n < 100);
        ok = a;
        if (!a) chk("accept_timeout", 256'(0), 256'(1));
    endtask

    task automatic check_outputs_zero(input string nm);
        chk({nm, "_ctrl"}, 256'({s_axis_tready, kernel_wr_en, kernel_wr_addr, pix_tvalid,
            pix_last_ch, pix_tlast, busy, done, err_early_tlast, err_missing_tlast, err_cfg}), 256'(0));
        chk({nm, "_kdata"}, kernel_wr_data, '0);
        chk({nm, "_pdata"}, pix_tdata, '0);
    endtask

    task automatic send(input int fid, input int isel, input int csel,
                        input int early_at, input bit no_tlast, input int rst_at);
        int  ch    = 256 >> csel;
        int  side  = 4 << isel;
        int  total = ch + side * side * ch;
        bit  ok;
        bit  is_early;
        bit  lastb;
        for (int k = 0; k < total; k++) begin
            if (rst_at >= 0 && k == ch + rst_at) begin
                s_axis_tvalid = 1'b0;
                aresetn = 1'b0;
                #1;
                check_outputs_zero("midframe_rst");
                kq.delete();
                pq.delete();
                @(posedge clk); #1;
                aresetn = 1'b1;
                return;
            end
            is_early = (early_at >= 0) && (k == ch + early_at);
            lastb    = (k == total - 1);
            if (!is_early) begin
                if (k < ch) kq.push_back('{CW'(k), dat(fid, k)});
                else        pq.push_back('{dat(fid, k), ((k - ch) % ch) == ch - 1, lastb});
            end
            s_axis_tdata  = dat(fid, k);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = is_early || (lastb && !no_tlast);
            wait_acc(ok);
            if (!ok || is_early) break;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 256'(busy), 256'(0));
    endtask

    task automatic run_frame(input int fid, input bit skip_start, input int isel, input int csel,
                             input int early_at, input bit no_tlast,
                             input int exp_k, input int exp_p, input int exp_done,
                             input logic [2:0] exp_err);
        int d0 = done_cnt;
        int k0 = kwr_seen;
        int p0 = pix_seen;
        if (!skip_start) do_start(3'(isel), 2'(csel));
        chk("start_busy", 256'(busy), 256'(1));
        chk("start_errs", 256'({err_early_tlast, err_missing_tlast, err_cfg}), 256'(0));
        send(fid, isel, csel, early_at, no_tlast, -1);
        wait_idle();
        chk("done_pulses", 256'(done_cnt - d0), 256'(exp_done));
        chk("kernel_writes", 256'(kwr_seen - k0), 256'(exp_k));
        chk("pix_beats", 256'(pix_seen - p0), 256'(exp_p));
        chk("pix_pending", 256'(pq.size() + kq.size()), 256'(0));
        chk("end_errs", 256'({err_early_tlast, err_missing_tlast, err_cfg}), 256'(exp_err));
    endtask

    initial begin
        aresetn = 1'b0; start = 1'b0; image_size_sel = '0; channel_size_sel = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; pix_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");

        // start held while reset releases: taken on the very next edge
        @(posedge clk); #1;
        aresetn = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_frame(1, 1'b1, 0, 0, -1, 1'b0, 256, 4096, 1, 3'b000);

        toggle_mode = 1'b1;
        run_frame(2, 1'b0, 0, 0, -1, 1'b0, 256, 4096, 1, 3'b000);
        toggle_mode = 1'b0;

        run_frame(3, 1'b0, 1, 3, -1, 1'b0, 32, 2048, 1, 3'b000);
        run_frame(4, 1'b0, 0, 0, 100, 1'b0, 256, 100, 0, 3'b100);
        run_frame(5, 1'b0, 0, 3, -1, 1'b1, 32, 512, 1, 3'b010);

        do_start(3'd5, 2'd0);
        chk("cfg_busy", 256'(busy), 256'(0));
        chk("cfg_errs", 256'({err_early_tlast, err_missing_tlast, err_cfg}), 256'(3'b001));
        repeat (3) @(posedge clk);
        #1 chk("cfg_still_idle", 256'({busy, s_axis_tready}), 256'(0));

        do_start(3'd0, 2'd0);
        chk("rst_frame_busy", 256'(busy), 256'(1));
        send(7, 0, 0, -1, 1'b0, 1000);
        chk("after_rst_idle", 256'(busy), 256'(0));
        run_frame(8, 1'b0, 0, 3, -1, 1'b0, 32, 512, 1, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
